// File: rtl/uart_ctl.sv
// UART controller: arbitrates two transmit requesters onto an Avalon-MM UART
// port and pulls received characters out of the UART into a one-entry holding
// register for a downstream consumer. Receive service always outranks transmit.
//
// BYTESIZE must not exceed ADW-3, so the parity bit (readdata[BYTESIZE]) and
// the overflow flag (readdata[ADW-2]) never collide with the character field.

module uart_ctl #(
   parameter int ADW      = 32,
   parameter int BYTESIZE = 8
) (
   input  logic                clk,
   input  logic                rst,

   // transmit requesters
   input  logic                req0_valid,
   input  logic [BYTESIZE-1:0] req0_data,
   output logic                req0_ready,
   input  logic                req1_valid,
   input  logic [BYTESIZE-1:0] req1_data,
   output logic                req1_ready,

   // receive consumer
   output logic                rx_valid,
   output logic [BYTESIZE-1:0] rx_data,
   output logic                rx_par,
   output logic                rx_ovf,
   input  logic                rx_ready,

   // UART side
   input  logic                uart_irq,
   output logic                avalon_read,
   output logic                avalon_write,
   output logic [ADW-1:0]      avalon_writedata,
   input  logic [ADW-1:0]      avalon_readdata,
   input  logic                avalon_waitrequest
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   state_t state;

   // Round-robin pointer: 0 means req0 wins a tie, 1 means req1 wins a tie.
   logic prefer1;

   logic read_go;
   logic grant0;
   logic grant1;
   logic [BYTESIZE-1:0] grant_data;
   logic [ADW-1:0]      grant_word;

   // Only the character, parity and overflow fields of readdata matter here.
   logic unused_readdata;
   assign unused_readdata = ^avalon_readdata;

   // Decide this cycle's IDLE action: pending receive first, otherwise a round-robin transmit grant
   always_comb begin
      read_go = 1'b0;
      grant0  = 1'b0;
      grant1  = 1'b0;
      if (!rst && state == IDLE) begin
         if (uart_irq && !rx_valid) begin
            read_go = 1'b1;
         end else if (req0_valid && (!req1_valid || !prefer1)) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Select the granted byte and zero-extend it to the bus width
   always_comb begin
      grant_data = grant1 ? req1_data : req0_data;
      grant_word = {{(ADW-BYTESIZE){1'b0}}, grant_data};
   end

   // Main controller: state, registered bus strobes, write data and receive holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         prefer1          <= 1'b0;
         avalon_read      <= 1'b0;
         avalon_write     <= 1'b0;
         avalon_writedata <= '0;
         rx_valid         <= 1'b0;
         rx_data          <= '0;
         rx_par           <= 1'b0;
         rx_ovf           <= 1'b0;
      end else begin
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (read_go) begin
                  state       <= READ;
                  avalon_read <= 1'b1;
               end else if (grant0 || grant1) begin
                  state            <= WRITE;
                  avalon_write     <= 1'b1;
                  avalon_writedata <= grant_word;
                  prefer1          <= grant0;
               end
            end

            WRITE: begin
               if (!avalon_waitrequest) begin
                  state            <= IDLE;
                  avalon_write     <= 1'b0;
                  avalon_writedata <= '0;
               end
            end

            READ: begin
               if (!avalon_waitrequest) begin
                  state       <= IDLE;
                  avalon_read <= 1'b0;
                  rx_valid    <= 1'b1;
                  rx_data     <= avalon_readdata[BYTESIZE-1:0];
                  rx_par      <= avalon_readdata[BYTESIZE];
                  rx_ovf      <= avalon_readdata[ADW-2];
               end
            end

            default: begin
               state            <= IDLE;
               avalon_read      <= 1'b0;
               avalon_write     <= 1'b0;
               avalon_writedata <= '0;
            end
         endcase
      end
   end

endmodule
